// File: rtl/regfile_multiport.sv
// regfile_multiport: two-read/one-write register file with byte enables, write bypass and a power-up clear sweep
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   readAddress1,
    input  logic [ADDR_WIDTH-1:0]   readAddress2,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic                    writeEnable,
    output logic [DATA_WIDTH-1:0]   readData1,
    output logic [DATA_WIDTH-1:0]   readData2,
    output logic                    ready,
    output logic                    writeDropped
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    drop_q, drop_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   merged, wr_val;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    run_wr, wr_en;

    // Merge enabled bytes of the incoming word over the stored entry
    always_comb begin
        merged = mem_q[writeAddress];
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = writeByteEnable[i] ? writeData[8*i +: 8] : mem_q[writeAddress][8*i +: 8];
    end

    // Next-state, sweep counter, drop flag and array write port selection
    always_comb begin
        run_wr  = state_q == RUN && writeEnable && |writeByteEnable && !(ZERO_REG != 0 && writeAddress == '0);
        state_d = (state_q == CLEAR && cnt_q == '1) ? RUN : state_q;
        cnt_d   = state_q == CLEAR ? cnt_q + ADDR_WIDTH'(1) : '0;
        drop_d  = writeEnable && state_q != RUN;
        wr_en   = !reset && (state_q == CLEAR || run_wr);
        wr_addr = state_q == CLEAR ? cnt_q : writeAddress;
        wr_val  = state_q == CLEAR ? '0 : merged;
    end

    // Control state with synchronous reset restarting the sweep
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Array storage: sweep clears or run-time byte-masked writes
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_addr] <= wr_val;
    end

    // Combinational read ports with zero-register, forwarding and not-ready masking
    always_comb begin
        readData1 = (state_q != RUN || (ZERO_REG != 0 && readAddress1 == '0)) ? '0 :
                    (BYPASS != 0 && run_wr && readAddress1 == writeAddress) ? merged : mem_q[readAddress1];
        readData2 = (state_q != RUN || (ZERO_REG != 0 && readAddress2 == '0)) ? '0 :
                    (BYPASS != 0 && run_wr && readAddress2 == writeAddress) ? merged : mem_q[readAddress2];
        ready        = state_q == RUN;
        writeDropped = drop_q;
    end
endmodule
